// File: rtl/uart_recv.sv
`timescale 1ns/1ps
// uart_recv: 8N1 serial receiver, line synchronised, start validated and every bit sampled at its centre.
// Latency: recv_done / frame_err pulse one SCLK after the mid-stop-bit sample (E + 9N + H + 1).
// Backpressure: none; downstream must accept every recv_done pulse, the byte is held until the next good frame.
module uart_recv (
  input  logic        SCLK,
  input  logic        RST_n,
  input  logic [12:0] rxBAUND_DATA,
  input  logic        data_rx,
  output logic [7:0]  o_RECV_DATA,
  output logic        recv_done,
  output logic        frame_err,
  output logic        UART_RX_busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic        s3_q, s3_d;
  logic [12:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        fall;
  logic        at_half;
  logic        at_wrap;
  logic [12:0] cnt_next;

  // Synchroniser chain plus history flop used for falling-edge detection.
  always_comb begin
    s1_d = data_rx;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Shared bit-timing decodes: centre-of-bit and end-of-bit positions of the counter.
  always_comb begin
    fall     = ~s2_q & s3_q;
    at_half  = (cnt_q == (rxBAUND_DATA >> 1));
    at_wrap  = (cnt_q == rxBAUND_DATA);
    cnt_next = at_wrap ? 13'd0 : cnt_q + 13'd1;
  end

  // Frame FSM: next state, bit counter, shift register and result pulses.
  // The edge cycle counts as cnt=0, so the counter leaves IDLE already at 1
  // and every sample lands at E + k*N + H.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 13'd0;
        if (fall) begin
          state_d = START;
          cnt_d   = 13'd1;
        end
      end
      START: begin
        cnt_d = cnt_next;
        if (at_half && s2_q) begin
          // Line back high at mid start bit: a glitch, not a frame.
          state_d = IDLE;
          cnt_d   = 13'd0;
        end else if (at_wrap) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        cnt_d = cnt_next;
        if (at_half) begin
          shift_d[bit_idx_q] = s2_q;
        end
        if (at_wrap) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        cnt_d = cnt_next;
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        if (at_half) begin
          state_d = IDLE;
          cnt_d   = 13'd0;
          if (s2_q) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 13'd0;
      end
    endcase
  end

  // State registers; synchroniser resets to the idle-high line level.
  always_ff @(posedge SCLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= IDLE;
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      s3_q      <= 1'b1;
      cnt_q     <= 13'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_RECV_DATA  = data_q;
  assign recv_done    = done_q;
  assign frame_err    = err_q;
  assign UART_RX_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_recv.sv
`timescale 1ns/1ps
// tb_uart_recv: scoreboard bench for the 8N1 receiver.
// Bytes are pushed to exp_q as frames are driven and popped on each recv_done.
// Timing, glitch, frame-error, reset and baud-skew cases use a bench-side transmitter.
module tb_uart_recv;

  logic        SCLK;
  logic        RST_n;
  logic [12:0] rxBAUND_DATA;
  logic        data_rx;
  logic [7:0]  o_RECV_DATA;
  logic        recv_done;
  logic        frame_err;
  logic        UART_RX_busy;

  uart_recv dut (
    .SCLK         (SCLK),
    .RST_n        (RST_n),
    .rxBAUND_DATA (rxBAUND_DATA),
    .data_rx      (data_rx),
    .o_RECV_DATA  (o_RECV_DATA),
    .recv_done    (recv_done),
    .frame_err    (frame_err),
    .UART_RX_busy (UART_RX_busy)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  int        n_checks = 0;
  int        n_errors = 0;
  int        cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  int        done_cnt = 0;
  int        err_cnt = 0;
  int        exp_done = 0;
  int        exp_err = 0;
  int        busy_cycles = 0;
  int        rise_cyc = 0;
  int        last_done_cyc = 0;
  int        done_lat = 0;
  int        done_gap = 0;
  logic      busy_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge SCLK) cyc++;

  // Output monitor, sampled on the falling edge.
  always @(negedge SCLK) begin
    logic [7:0] e;
    if (UART_RX_busy && !busy_prev) rise_cyc = cyc;
    busy_prev = UART_RX_busy;
    if (UART_RX_busy) busy_cycles++;
    if (recv_done) begin
      done_cnt++;
      done_lat      = cyc - rise_cyc;
      done_gap      = cyc - last_done_cyc;
      last_done_cyc = cyc;
      chk("done_err_overlap", {31'd0, frame_err}, 32'd0);
      chk("done_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rx_data", {24'd0, o_RECV_DATA}, {24'd0, e});
        last_good = e;
      end
    end
    if (frame_err) begin
      err_cnt++;
      chk("err_data_hold", {24'd0, o_RECV_DATA}, {24'd0, last_good});
    end
  end

  // Cycle-aligned transmitter: each bit lasts exactly n SCLK cycles.
  task automatic tx_frame(input logic [7:0] d, input logic stop_b, input int n);
    logic [9:0] f;
    f = {stop_b, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      data_rx = f[i];
      repeat (n) @(posedge SCLK);
      #1;
    end
  endtask

  // Free-running transmitter with a real-valued bit time, for baud skew.
  task automatic tx_frame_t(input logic [7:0] d, input realtime bt);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      data_rx = f[i];
      #(bt);
    end
  endtask

  task automatic send_good(input logic [7:0] d, input int n);
    exp_q.push_back(d);
    exp_done++;
    tx_frame(d, 1'b1, n);
  endtask

  task automatic idle(input int n);
    data_rx = 1'b1;
    repeat (n) @(posedge SCLK);
    #1;
  endtask

  initial begin
    logic [9:0] f;
    logic [7:0] d;
    int         dc;

    RST_n        = 1'b0;
    data_rx      = 1'b1;
    rxBAUND_DATA = 13'd15;
    #12;
    chk("rst_data", {24'd0, o_RECV_DATA}, 32'h00);
    chk("rst_done", {31'd0, recv_done}, 32'd0);
    chk("rst_err",  {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, UART_RX_busy}, 32'd0);
    #10 RST_n = 1'b1;
    idle(20);

    // Single frame: latency from busy rise (E+1) to recv_done (E+9N+H+1) is 9N+H.
    send_good(8'hA5, 16);
    idle(30);
    chk("t1_done_cnt", done_cnt, exp_done);
    chk("t1_latency", done_lat, 9 * 16 + 7);
    chk("t1_data", {24'd0, o_RECV_DATA}, 32'hA5);

    // Back-to-back frames, one stop bit each.
    send_good(8'h00, 16);
    send_good(8'hFF, 16);
    idle(30);
    chk("b2b_done_cnt", done_cnt, exp_done);
    chk("b2b_gap", done_gap, 160);
    chk("b2b_err_cnt", err_cnt, exp_err);

    // 4-cycle low glitch: busy for E+1..E+7, then a quiet return to idle.
    busy_cycles = 0;
    dc = done_cnt;
    data_rx = 1'b0;
    repeat (4) @(posedge SCLK);
    #1;
    idle(40);
    chk("glitch_busy_cycles", busy_cycles, 7);
    chk("glitch_no_done", done_cnt, dc);
    chk("glitch_no_err", err_cnt, exp_err);
    chk("glitch_data_hold", {24'd0, o_RECV_DATA}, 32'hFF);

    // Frame error sandwiched between good frames.
    send_good(8'h11, 16);
    idle(20);
    tx_frame(8'h3C, 1'b0, 16);
    exp_err++;
    idle(40);
    chk("ferr_cnt", err_cnt, exp_err);
    chk("ferr_data_hold", {24'd0, o_RECV_DATA}, 32'h11);
    send_good(8'h5A, 16);
    idle(30);
    chk("ferr_next_done", done_cnt, exp_done);
    chk("ferr_next_data", {24'd0, o_RECV_DATA}, 32'h5A);

    // Reset in the middle of data bit 4 of 0xC3.
    dc = done_cnt;
    f = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 5; i++) begin
      data_rx = f[i];
      repeat (16) @(posedge SCLK);
      #1;
    end
    data_rx = f[5];
    repeat (8) @(posedge SCLK);
    #2 RST_n = 1'b0;
    #1;
    chk("mrst_data", {24'd0, o_RECV_DATA}, 32'h00);
    chk("mrst_busy", {31'd0, UART_RX_busy}, 32'd0);
    chk("mrst_done", {31'd0, recv_done}, 32'd0);
    chk("mrst_err",  {31'd0, frame_err}, 32'd0);
    last_good = 8'h00;
    data_rx = 1'b1;
    repeat (3) @(posedge SCLK);
    #1 RST_n = 1'b1;
    idle(40);
    chk("mrst_no_pulse", done_cnt, dc);
    send_good(8'h96, 16);
    idle(30);
    chk("mrst_next_data", {24'd0, o_RECV_DATA}, 32'h96);

    // Loopback-style run at divider 433 with random bytes.
    rxBAUND_DATA = 13'd433;
    idle(10);
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      send_good(d, 434);
    end
    idle(500);
    chk("lb433_done_cnt", done_cnt, exp_done);

    // +/-2 % baud skew at N=16 (10 ns clock, nominal bit 160 ns).
    rxBAUND_DATA = 13'd15;
    idle(10);
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom_range(0, 255));
      exp_q.push_back(d);
      exp_done++;
      tx_frame_t(d, 163.2);
    end
    idle(40);
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom_range(0, 255));
      exp_q.push_back(d);
      exp_done++;
      tx_frame_t(d, 156.8);
    end
    idle(40);
    chk("skew_done_cnt", done_cnt, exp_done);
    chk("final_err_cnt", err_cnt, exp_err);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
